// File: rtl/int_pe_ws.sv
// Weight-stationary INT PE: LANES-wide dot product with a two-stage pipeline,
// a shift-load weight chain and an output-stationary accumulate/drain mode.
// Optional saturating adders are enabled by defining INT_PE_SAT_EN.
module int_pe_ws #(
  parameter int WORD_SIZE     = 4,
  parameter int LANES         = 2,
  parameter int ADD_BIT_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fsm_out_select_in,
  input  logic                         sign_in,
  input  logic                         w_load_in,
  input  logic [LANES*WORD_SIZE-1:0]   w_in,
  output logic [LANES*WORD_SIZE-1:0]   w_out,
  output logic                         w_load_out,
  input  logic                         left_valid_in,
  input  logic [LANES*WORD_SIZE-1:0]   left_in,
  output logic                         right_valid_out,
  output logic [LANES*WORD_SIZE-1:0]   right_out,
  input  logic [ADD_BIT_WIDTH-1:0]     top_in,
  input  logic                         drain_in,
  output logic                         bottom_valid_out,
  output logic [ADD_BIT_WIDTH-1:0]     bottom_out
);

  localparam int BUS_W  = LANES * WORD_SIZE;
  localparam int PROD_W = 2 * WORD_SIZE;

  logic [BUS_W-1:0]         w_reg;
  logic [PROD_W-1:0]        prod_c  [LANES];
  logic [PROD_W-1:0]        prod_s1 [LANES];
  logic [ADD_BIT_WIDTH-1:0] top_s1;
  logic                     mode_s1;
  logic                     sign_s1;
  logic                     valid_s1;
  logic [ADD_BIT_WIDTH-1:0] acc;
  logic [ADD_BIT_WIDTH-1:0] dot;
  logic [ADD_BIT_WIDTH-1:0] dot_acc;
  logic [ADD_BIT_WIDTH-1:0] ws_sum;
  logic [ADD_BIT_WIDTH-1:0] os_sum;
  logic                     eff_ws;

  assign w_out = w_reg;

  // Both operands are extended to PROD_W so the low PROD_W bits of the
  // product are exact for either signed or unsigned interpretation.
  always_comb begin : lane_mult
    logic [WORD_SIZE-1:0] a_lane;
    logic [WORD_SIZE-1:0] w_lane;
    logic [PROD_W-1:0]    a_ext;
    logic [PROD_W-1:0]    w_ext;
    // NOTE: every combinational output and temporary gets a value on every path, so no latch is inferred.
    a_lane = '0;
    w_lane = '0;
    a_ext  = '0;
    w_ext  = '0;
    for (int i = 0; i < LANES; i++) begin
      a_lane = left_in[i*WORD_SIZE +: WORD_SIZE];
      w_lane = w_reg[i*WORD_SIZE +: WORD_SIZE];
      if (sign_in) begin
        a_ext = PROD_W'(signed'(a_lane));
        w_ext = PROD_W'(signed'(w_lane));
      end else begin
        a_ext = PROD_W'(a_lane);
        w_ext = PROD_W'(w_lane);
      end
      prod_c[i] = a_ext * w_ext;
    end
  end

  always_comb begin : dot_sum
    logic [ADD_BIT_WIDTH-1:0] term;
    term = '0;
    dot  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sign_s1) term = ADD_BIT_WIDTH'(signed'(prod_s1[i]));
      else         term = ADD_BIT_WIDTH'(prod_s1[i]);
      dot = dot + term;
    end
  end

`ifdef INT_PE_SAT_EN
  function automatic logic [ADD_BIT_WIDTH-1:0] sat_add(
    input logic [ADD_BIT_WIDTH-1:0] a,
    input logic [ADD_BIT_WIDTH-1:0] b,
    input logic                     sgn
  );
    logic [ADD_BIT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (sgn) begin
      // Signed overflow: operands agree in sign but the result does not.
      if ((a[ADD_BIT_WIDTH-1] == b[ADD_BIT_WIDTH-1]) &&
          (s[ADD_BIT_WIDTH-1] != a[ADD_BIT_WIDTH-1]))
        return a[ADD_BIT_WIDTH-1] ? {1'b1, {(ADD_BIT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ADD_BIT_WIDTH-1){1'b1}}};
    end else if (s[ADD_BIT_WIDTH]) begin
      return '1;
    end
    return s[ADD_BIT_WIDTH-1:0];
  endfunction

  assign ws_sum = sat_add(top_s1, dot, sign_s1);
  assign os_sum = sat_add(acc, dot_acc, sign_s1);
`else
  assign ws_sum = top_s1 + dot;
  assign os_sum = acc + dot_acc;
`endif

  assign dot_acc = (valid_s1 && !mode_s1) ? dot : '0;
  // In-flight results follow the mode they were issued in; idle cycles use the live mode.
  assign eff_ws  = valid_s1 ? mode_s1 : fsm_out_select_in;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_reg           <= '0;
      w_load_out      <= 1'b0;
      right_out       <= '0;
      right_valid_out <= 1'b0;
    end else begin
      if (w_load_in) w_reg <= w_in;
      w_load_out      <= w_load_in;
      right_out       <= left_in;
      right_valid_out <= left_valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) prod_s1[i] <= '0;
      top_s1   <= '0;
      mode_s1  <= 1'b0;
      sign_s1  <= 1'b0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= left_valid_in;
      if (left_valid_in) begin
        for (int i = 0; i < LANES; i++) prod_s1[i] <= prod_c[i];
        top_s1  <= top_in;
        mode_s1 <= fsm_out_select_in;
        sign_s1 <= sign_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc              <= '0;
      bottom_out       <= '0;
      bottom_valid_out <= 1'b0;
    end else if (eff_ws) begin
      bottom_valid_out <= valid_s1;
      if (valid_s1) bottom_out <= ws_sum;
    end else if (drain_in) begin
      bottom_out       <= os_sum;
      bottom_valid_out <= 1'b1;
      acc              <= '0;
    end else begin
      bottom_out       <= top_in;
      bottom_valid_out <= 1'b0;
      acc              <= os_sum;
    end
  end

endmodule
